// File: rtl/barerom_loader_if.sv
// Byte-stream input and RAM write port of barerom_loader.
// slave: the loader side; master: the byte source / RAM side.
interface barerom_loader_if #(
    parameter int WIDTH = 32,
    parameter int SCALE = 10
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             ram_we;
    logic [SCALE-1:0] ram_addr;
    logic [WIDTH-1:0] ram_wdata;

    modport slave (
        input  in_valid, in_data,
        output in_ready, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/barerom_loader.sv
// Loads len little-endian words from a byte stream into a BARERAM write port.
// Define BAREROM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module barerom_loader #(
    parameter int WIDTH = 32,
    parameter int SCALE = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SCALE:0]    len,
    barerom_loader_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int NB = WIDTH / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0]    IDX_LAST = IW'(NB - 1);
    localparam logic [IW-1:0]    IDX_ONE  = IW'(1);
    localparam logic [SCALE-1:0] ADDR_ONE = SCALE'(1);
    localparam logic [SCALE:0]   CNT_ONE  = (SCALE + 1)'(1);

    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, FIN} state_t;

    state_t           state_q, state_d;
    logic [SCALE-1:0] addr_q, addr_d;
    logic [SCALE:0]   cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             ram_we_q, ram_we_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             xfer;
`ifdef BAREROM_LOADER_CHECKSUM_EN
    logic [7:0]       sum_q, sum_d;
    logic             err_q, err_d;
`endif

    assign xfer = bus.in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        word_d  = word_q;
`ifdef BAREROM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = len;
                    addr_d  = '0;
                    idx_d   = '0;
`ifdef BAREROM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                    state_d = (len == '0) ? FIN : COLLECT;
                end
            end
            COLLECT: begin
                if (xfer) begin
                    word_d[8*idx_q +: 8] = bus.in_data;
`ifdef BAREROM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + bus.in_data;
`endif
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = WRITE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            WRITE: begin
                // The address wrap after a full 2**SCALE-word load is harmless.
                addr_d = addr_q + ADDR_ONE;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
`ifdef BAREROM_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = FIN;
`endif
                end else begin
                    state_d = COLLECT;
                end
            end
            CHECK: begin
`ifdef BAREROM_LOADER_CHECKSUM_EN
                if (xfer) begin
                    if ((sum_q + bus.in_data) != 8'd0) err_d = 1'b1;
                    state_d = FIN;
                end
`else
                state_d = FIN;
`endif
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs follow the next state so they are valid for the whole state.
        ram_we_d   = (state_d == WRITE);
        in_ready_d = (state_d == COLLECT) || (state_d == CHECK);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            ram_we_q   <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef BAREROM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            ram_we_q   <= ram_we_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef BAREROM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = word_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef BAREROM_LOADER_CHECKSUM_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_barerom_loader.sv
// Self-checking bench for barerom_loader: directed loads plus random loads
// compared against a word/checksum model built from the byte list.
module tb_barerom_loader;

    localparam int WIDTH = 32;
    localparam int SCALE = 3;
    localparam int NB    = WIDTH / 8;
    localparam int DEPTH = 1 << SCALE;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [SCALE:0] len;
    logic           busy, done, err;

    barerom_loader_if #(.WIDTH(WIDTH), .SCALE(SCALE)) bus ();

    barerom_loader #(.WIDTH(WIDTH), .SCALE(SCALE)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .len   (len),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int               wr_addr_q[$];
    logic [WIDTH-1:0] wr_data_q[$];
    int               done_cnt;
    int               consumed;
    int               ready_in_write;
    logic             err_at_done;

    // Observe the DUT mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_we) begin
                wr_addr_q.push_back(int'(bus.ram_addr));
                wr_data_q.push_back(bus.ram_wdata);
            end
            if (bus.in_valid && bus.in_ready) consumed++;
            if (bus.ram_we && bus.in_ready) ready_in_write++;
            if (done) begin
                done_cnt++;
                err_at_done = err;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt       = 0;
        consumed       = 0;
        ready_in_write = 0;
        err_at_done    = 1'bx;
    endtask

    function automatic logic [WIDTH-1:0] word_of(input logic [7:0] q[$], input int w);
        logic [63:0] acc = 64'd0;
        for (int k = 0; k < NB; k++)
            acc = acc + 64'(q[w*NB + k]) * (64'd1 << (8*k));
        return WIDTH'(acc);
    endfunction

    function automatic logic [7:0] sum_of(input logic [7:0] q[$]);
        int s = 0;
        foreach (q[i]) s = s + int'(q[i]);
        return 8'(s % 256);
    endfunction

    task automatic do_start(input int l);
        start = 1'b1;
        len   = (SCALE + 1)'(l);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input string tag, input logic [7:0] q[$], input bit toggle, input bit poke);
        int i    = 0;
        int iter = 0;
        bit acc;
        while (i < q.size() && iter < 400) begin
            bus.in_valid = toggle ? (iter % 2 == 0) : 1'b1;
            bus.in_data  = bus.in_valid ? q[i] : 8'($urandom);
            if (poke) begin
                start = (iter == 1);
                if (iter == 1) len = (SCALE + 1)'(1);
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            iter++;
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        check({tag, "_bytes_taken"}, 64'(i), 64'(q.size()));
    endtask

    task automatic wait_done(input string tag, input bit poke_fin, output int lat);
        int c    = 0;
        bit seen = 1'b0;
        while (!seen && c < 300) begin
            @(negedge clk);
            c++;
            if (done) seen = 1'b1;
        end
        if (seen && poke_fin) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        lat = c;
    endtask

    task automatic run_load(input string tag, input int l, input bit toggle, input bit poke,
                            input bit poke_fin, input logic [7:0] bq[$], input logic [7:0] trail);
        logic [7:0] fq[$];
        logic       exp_err;
        int         lat;
        fq      = bq;
        exp_err = 1'b0;
`ifdef BAREROM_LOADER_CHECKSUM_EN
        if (l > 0) begin
            fq.push_back(trail);
            exp_err = ((int'(sum_of(bq)) + int'(trail)) % 256) != 0;
        end
`else
        if (trail != 8'h00) exp_err = 1'b0;
`endif
        clear_mon();
        do_start(l);
        feed(tag, fq, toggle, poke);
        wait_done(tag, poke_fin, lat);
        @(posedge clk); #1;
        check({tag, "_nwrites"}, 64'(wr_addr_q.size()), 64'(l));
        for (int w = 0; w < l; w++) begin
            if (w < wr_addr_q.size()) begin
                check({tag, "_addr"}, 64'(wr_addr_q[w]), 64'(w));
                check({tag, "_wdata"}, 64'(wr_data_q[w]), 64'(word_of(bq, w)));
            end
        end
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_consumed"}, 64'(consumed), 64'(fq.size()));
        check({tag, "_ready_in_write"}, 64'(ready_in_write), 64'd0);
        check({tag, "_err"}, 64'(err_at_done), 64'(exp_err));
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [7:0] bq[$];
        int         lat;
        int         l;

        rst          = 1'b1;
        start        = 1'b0;
        len          = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ram_we", 64'(bus.ram_we), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load("basic", 2, 1'b0, 1'b0, 1'b0, bq, 8'hDC);
        if (wr_data_q.size() == 2) begin
            check("basic_w0_const", 64'(wr_data_q[0]), 64'h04030201);
            check("basic_w1_const", 64'(wr_data_q[1]), 64'h08070605);
        end

        // Zero-length load with a byte waiting on the stream.
        clear_mon();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        do_start(0);
        wait_done("len0", 1'b0, lat);
        bus.in_valid = 1'b0;
        check("len0_latency_le2", 64'(lat <= 2), 64'd1);
        check("len0_nwrites", 64'(wr_addr_q.size()), 64'd0);
        check("len0_consumed", 64'(consumed), 64'd0);
        check("len0_err", 64'(err_at_done), 64'd0);
        check("len0_busy_after", 64'(busy), 64'd0);

        bq = {8'h01, 8'h02, 8'h03, 8'h04};
        run_load("toggle", 1, 1'b1, 1'b0, 1'b0, bq, 8'hF6);
        if (wr_data_q.size() == 1)
            check("toggle_w0_const", 64'(wr_data_q[0]), 64'h04030201);

        // Reset partway through word 0.
        clear_mon();
        do_start(1);
        bq = {8'h11, 8'h22, 8'h33};
        feed("midrst", bq, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        check("midrst_ram_we", 64'(bus.ram_we), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("midrst_nwrites", 64'(wr_addr_q.size()), 64'd0);
        check("midrst_done_pulses", 64'(done_cnt), 64'd0);
        bq = {8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_load("postrst", 1, 1'b0, 1'b0, 1'b0, bq, 8'hDC);

        // Start pokes while busy and during the done cycle.
        bq.delete();
        repeat (2 * NB) bq.push_back(8'($urandom));
        run_load("poke", 2, 1'b0, 1'b1, 1'b1, bq, 8'h00);
        check("poke_idle_after_fin", 64'(busy), 64'd0);

`ifdef BAREROM_LOADER_CHECKSUM_EN
        bq = {8'h10, 8'h20, 8'h30, 8'h40};
        run_load("cks_good", 1, 1'b0, 1'b0, 1'b0, bq, 8'h60);
        run_load("cks_bad", 1, 1'b0, 1'b0, 1'b0, bq, 8'h61);
        repeat (3) @(posedge clk);
        #1;
        check("cks_err_held", 64'(err), 64'd1);
        run_load("cks_clear", 1, 1'b0, 1'b0, 1'b0, bq, 8'h60);
`endif

        bq.delete();
        repeat (DEPTH * NB) bq.push_back(8'($urandom));
        run_load("full", DEPTH, 1'b0, 1'b0, 1'b0, bq, 8'($urandom));
        if (wr_addr_q.size() == DEPTH)
            check("full_last_addr", 64'(wr_addr_q[DEPTH-1]), 64'(DEPTH - 1));

        for (int t = 0; t < 8; t++) begin
            l = int'($urandom_range(DEPTH, 1));
            bq.delete();
            repeat (l * NB) bq.push_back(8'($urandom));
            run_load("rand", l, 1'($urandom), 1'b0, 1'b0, bq, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
